// File: rtl/control_unit.sv
// Hardwired microsequencer: walks fetch/execute states and decodes the opcode into
// the per-cycle control word C0..C12, ALU function and retired-instruction count.
module control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [7:0]       IR_in,
  input  logic             acc_neg,
  output logic [12:0]      ctrl,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_E0   = 3'd4,
    S_E1   = 3'd5,
    S_E2   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_STORE  = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_AND    = 8'h05;
  localparam logic [7:0] OP_OR     = 8'h06;
  localparam logic [7:0] OP_JMP    = 8'h07;
  localparam logic [7:0] OP_JMPGEZ = 8'h08;
  localparam logic [7:0] OP_CLRA   = 8'h09;
  localparam logic [7:0] OP_HALT   = 8'h0A;

  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;

  state_t           r_state;
  state_t           w_next;
  state_t           w_after;
  logic [12:0]      w_ctrl;
  logic [2:0]       w_alu_op;
  logic             w_retire;
  logic             w_illegal;
  logic [CNT_W-1:0] r_instr_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
    end else if (w_retire) begin
      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end else begin
      r_instr_cnt <= r_instr_cnt;
    end
  end

  // Next-state and control-word decode
  always_comb begin
    w_next    = r_state;
    w_ctrl    = 13'd0;
    w_alu_op  = ALU_PASS_B;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    // run is only consulted at an instruction boundary
    w_after   = run ? S_F0 : S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next = S_F0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_F0: begin
        w_ctrl[0] = 1'b1;
        w_next    = S_F1;
      end
      S_F1: begin
        w_ctrl[2] = 1'b1;
        w_ctrl[1] = 1'b1;
        w_next    = S_F2;
      end
      S_F2: begin
        w_ctrl[4] = 1'b1;
        w_ctrl[5] = 1'b1;
        w_next    = S_E0;
      end
      S_E0: begin
        case (IR_in)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ctrl[2] = 1'b1;
            w_next    = S_E1;
          end
          OP_STORE: begin
            w_ctrl[7] = 1'b1;
            w_next    = S_E1;
          end
          OP_JMP: begin
            w_ctrl[6] = 1'b1;
            w_retire  = 1'b1;
            w_next    = w_after;
          end
          OP_JMPGEZ: begin
            w_ctrl[6] = ~acc_neg;
            w_retire  = 1'b1;
            w_next    = w_after;
          end
          OP_CLRA: begin
            w_ctrl[10] = 1'b1;
            w_retire   = 1'b1;
            w_next     = w_after;
          end
          OP_NOP: begin
            w_retire = 1'b1;
            w_next   = w_after;
          end
          OP_HALT: begin
            w_retire = 1'b1;
            w_next   = S_HALT;
          end
          default: begin
            w_illegal = 1'b1;
            w_next    = w_after;
          end
        endcase
      end
      S_E1: begin
        case (IR_in)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ctrl[8] = 1'b1;
            w_next    = S_E2;
          end
          OP_STORE: begin
            w_ctrl[3] = 1'b1;
            w_retire  = 1'b1;
            w_next    = w_after;
          end
          default: begin
            w_next = S_IDLE;
          end
        endcase
      end
      S_E2: begin
        case (IR_in)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ctrl[9] = 1'b1;
            w_retire  = 1'b1;
            w_next    = w_after;
            case (IR_in)
              OP_ADD:  w_alu_op = ALU_ADD;
              OP_SUB:  w_alu_op = ALU_SUB;
              OP_AND:  w_alu_op = ALU_AND;
              OP_OR:   w_alu_op = ALU_OR;
              default: w_alu_op = ALU_PASS_B;
            endcase
          end
          default: begin
            w_next = S_IDLE;
          end
        endcase
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign ctrl       = w_ctrl;
  assign alu_op     = w_alu_op;
  assign illegal_op = w_illegal;
  assign halted     = (r_state == S_HALT);
  assign instr_cnt  = r_instr_cnt;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: fetch sequence, execute decode, run
// handling, illegal opcodes, HALT, async reset and counter wrap (narrow instance).
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [7:0]  IR_in;
  logic        acc_neg;
  logic [12:0] ctrl;
  logic [2:0]  alu_op;
  logic        halted;
  logic        illegal_op;
  logic [15:0] instr_cnt;

  logic        rst2_n;
  logic [12:0] ctrl2;
  logic [2:0]  alu_op2;
  logic        halted2;
  logic        illegal2;
  logic [3:0]  instr_cnt2;

  int n_vec;
  int n_err;

  control_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .IR_in(IR_in), .acc_neg(acc_neg),
    .ctrl(ctrl), .alu_op(alu_op), .halted(halted), .illegal_op(illegal_op),
    .instr_cnt(instr_cnt)
  );

  control_unit #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst2_n), .run(1'b1), .IR_in(8'h00), .acc_neg(1'b0),
    .ctrl(ctrl2), .alu_op(alu_op2), .halted(halted2), .illegal_op(illegal2),
    .instr_cnt(instr_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walk F0..F2 from the F0 sample point, loading opcode during F2
  task automatic fetch(input logic [7:0] op);
    chk("F0 ctrl", 32'(ctrl), 32'h001);
    step();
    chk("F1 ctrl", 32'(ctrl), 32'h006);
    step();
    IR_in = op;
    chk("F2 ctrl", 32'(ctrl), 32'h030);
    step();
  endtask

  logic [7:0] alu_ops [4];
  logic [2:0] alu_fn  [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    alu_ops[0] = 8'h01; alu_fn[0] = 3'd0;
    alu_ops[1] = 8'h04; alu_fn[1] = 3'd2;
    alu_ops[2] = 8'h05; alu_fn[2] = 3'd3;
    alu_ops[3] = 8'h06; alu_fn[3] = 3'd4;
    rst_n   = 1'b0;
    rst2_n  = 1'b0;
    run     = 1'b1;
    IR_in   = 8'h00;
    acc_neg = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst ctrl", 32'(ctrl), 32'h000);
    chk("rst cnt", 32'(instr_cnt), 32'h0);
    chk("rst halted", 32'(halted), 32'h0);
    chk("rst illegal", 32'(illegal_op), 32'h0);
    chk("rst alu_op", 32'(alu_op), 32'h0);
    rst_n = 1'b1;
    step();

    // ADD: 3-cycle execute, retire at E2
    fetch(8'h03);
    chk("ADD E0", 32'(ctrl), 32'h004);
    step();
    chk("ADD E1", 32'(ctrl), 32'h100);
    step();
    chk("ADD E2", 32'(ctrl), 32'h200);
    chk("ADD alu", 32'(alu_op), 32'd1);
    chk("ADD cnt pre", 32'(instr_cnt), 32'd0);
    step();
    chk("ADD cnt", 32'(instr_cnt), 32'd1);

    // JMPGEZ with negative and non-negative ACC
    acc_neg = 1'b1;
    fetch(8'h08);
    chk("JMPGEZ neg E0", 32'(ctrl), 32'h000);
    step();
    chk("JMPGEZ neg cnt", 32'(instr_cnt), 32'd2);
    acc_neg = 1'b0;
    fetch(8'h08);
    chk("JMPGEZ pos E0", 32'(ctrl), 32'h040);
    step();
    chk("JMPGEZ pos cnt", 32'(instr_cnt), 32'd3);

    // Illegal opcode
    fetch(8'hFF);
    chk("ILL pulse", 32'(illegal_op), 32'h1);
    chk("ILL ctrl", 32'(ctrl), 32'h000);
    step();
    chk("ILL pulse end", 32'(illegal_op), 32'h0);
    chk("ILL cnt", 32'(instr_cnt), 32'd3);

    // STORE with run dropped in E1
    fetch(8'h02);
    chk("STORE E0", 32'(ctrl), 32'h080);
    step();
    chk("STORE E1", 32'(ctrl), 32'h008);
    run = 1'b0;
    step();
    chk("IDLE ctrl", 32'(ctrl), 32'h000);
    chk("STORE cnt", 32'(instr_cnt), 32'd4);
    step();
    chk("IDLE hold", 32'(ctrl), 32'h000);
    run = 1'b1;
    step();

    // Remaining ALU ops: check E2 function code
    for (int i = 0; i < 4; i++) begin
      fetch(alu_ops[i]);
      step();
      step();
      chk("ALU E2 ctrl", 32'(ctrl), 32'h200);
      chk("ALU E2 fn", 32'(alu_op), 32'(alu_fn[i]));
      step();
    end
    chk("ALU cnt", 32'(instr_cnt), 32'd8);

    fetch(8'h09);
    chk("CLRA E0", 32'(ctrl), 32'h400);
    step();

    // HALT
    fetch(8'h0A);
    chk("HALT E0", 32'(ctrl), 32'h000);
    chk("HALT E0 halted", 32'(halted), 32'h0);
    step();
    chk("HALT halted", 32'(halted), 32'h1);
    chk("HALT cnt", 32'(instr_cnt), 32'd10);
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      step();
      chk("HALT ctrl", 32'(ctrl), 32'h000);
      chk("HALT stay", 32'(halted), 32'h1);
    end
    rst_n = 1'b0;
    #1;
    chk("async halted", 32'(halted), 32'h0);
    chk("async cnt", 32'(instr_cnt), 32'h0);
    chk("async ctrl", 32'(ctrl), 32'h000);

    // Counter wrap on a 4-bit instance running NOPs (4 cycles each)
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (61) step();
    chk("wrap pre", 32'(instr_cnt2), 32'hF);
    repeat (4) step();
    chk("wrap", 32'(instr_cnt2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
